// File: rtl/id_inst_queue.sv
// Dual-issue instruction queue between fetch and the two decode lanes (A/B).
// Latency: an entry enqueued at edge N is visible on the outputs from cycle N+1 (no bypass).
// Backpressure: in_ready needs room for two entries, based on the registered count only; lane B never dequeues ahead of lane A.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   flush                      discard all entries; gates out_valid low in the same cycle
//   in_valid[1:0]              fetch slots valid (slot 0 older; 2'b10 is ignored)
//   in_ir0/1, in_pc0/1,
//   in_pred0/1                 fetched instruction, PC, predictor info per slot
//   in_ready                   queue can take two entries this cycle
//   out_valid[1:0]             head / head+1 valid
//   out_ir0/1, out_pc0/1,
//   out_pred0/1                head / head+1 entry, zero when the matching valid bit is low
//   out_ready[1:0]             decode lanes accept; [1] only honoured together with [0]
module id_inst_queue #(
    parameter int DEPTH  = 8,
    parameter int PRED_W = 34
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [1:0]        in_valid,
    input  logic [31:0]       in_ir0,
    input  logic [31:0]       in_ir1,
    input  logic [31:0]       in_pc0,
    input  logic [31:0]       in_pc1,
    input  logic [PRED_W-1:0] in_pred0,
    input  logic [PRED_W-1:0] in_pred1,
    output logic              in_ready,
    output logic [1:0]        out_valid,
    output logic [31:0]       out_ir0,
    output logic [31:0]       out_ir1,
    output logic [31:0]       out_pc0,
    output logic [31:0]       out_pc1,
    output logic [PRED_W-1:0] out_pred0,
    output logic [PRED_W-1:0] out_pred1,
    input  logic [1:0]        out_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_TWO  = CW'(2);
    localparam logic [CW-1:0] ROOM_MAX = CW'(DEPTH - 2);

    // Storage is deliberately not reset; validity comes from count alone.
    logic [31:0]       ir_mem   [DEPTH];
    logic [31:0]       pc_mem   [DEPTH];
    logic [PRED_W-1:0] pred_mem [DEPTH];

    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [CW-1:0] count;

    logic [AW-1:0] head_p1;
    logic [AW-1:0] tail_p1;
    logic          enq_en;
    logic [1:0]    enq_num;
    logic          fire0;
    logic          fire1;
    logic [1:0]    deq_num;

    // Power-of-two depth: plain AW-bit add wraps DEPTH-1 -> 0.
    assign head_p1 = head + PTR_ONE;
    assign tail_p1 = tail + PTR_ONE;

    // Two free slots required regardless of any same-cycle dequeue, which
    // keeps out_ready off the in_ready path.
    assign in_ready = (count <= ROOM_MAX);

    assign enq_en = in_ready & ~flush;

    always_comb begin
        enq_num = 2'd0;
        if (enq_en) begin
            case (in_valid)
                2'b11:   enq_num = 2'd2;
                2'b01:   enq_num = 2'd1;
                default: enq_num = 2'd0;
            endcase
        end
    end

    assign out_valid[0] = (count >= CNT_ONE) & ~flush;
    assign out_valid[1] = (count >= CNT_TWO) & ~flush;

    assign fire0   = out_valid[0] & out_ready[0];
    assign fire1   = fire0 & out_valid[1] & out_ready[1];
    assign deq_num = {1'b0, fire0} + {1'b0, fire1};

    assign out_ir0   = out_valid[0] ? ir_mem[head]      : '0;
    assign out_pc0   = out_valid[0] ? pc_mem[head]      : '0;
    assign out_pred0 = out_valid[0] ? pred_mem[head]    : '0;
    assign out_ir1   = out_valid[1] ? ir_mem[head_p1]   : '0;
    assign out_pc1   = out_valid[1] ? pc_mem[head_p1]   : '0;
    assign out_pred1 = out_valid[1] ? pred_mem[head_p1] : '0;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + AW'(deq_num);
            tail  <= tail + AW'(enq_num);
            count <= count + CW'(enq_num) - CW'(deq_num);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && enq_num != 2'd0) begin
            ir_mem[tail]   <= in_ir0;
            pc_mem[tail]   <= in_pc0;
            pred_mem[tail] <= in_pred0;
            if (enq_num == 2'd2) begin
                ir_mem[tail_p1]   <= in_ir1;
                pc_mem[tail_p1]   <= in_pc1;
                pred_mem[tail_p1] <= in_pred1;
            end
        end
    end

endmodule
